// File: rtl/ibex_mem_xbar.sv
// Two-host by two-device request router between the Ibex instr/data ports and
// the on-chip SRAM / debug memory, with round-robin arbitration and a 1-deep response tag.
module ibex_mem_xbar #(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter logic [31:0] MemMask  = 32'h0000_FFFF,
    parameter logic [31:0] DbgStart = 32'h1000_0000,
    parameter logic [31:0] DbgMask  = 32'h0000_0FFF,
    parameter logic [31:0] ErrRdata = 32'hBADC_AB1E
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        dbg_req_o,
    output logic        dbg_we_o,
    output logic [3:0]  dbg_be_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_wdata_o,
    input  logic        dbg_rvalid_i,
    input  logic [31:0] dbg_rdata_i
);

    typedef enum logic {
        HOST_INSTR = 1'b0,
        HOST_DATA  = 1'b1
    } host_e;

    typedef enum logic [1:0] {
        DEV_MEM = 2'd0,
        DEV_DBG = 2'd1,
        DEV_ERR = 2'd2
    } dev_e;

    host_e       last_q;
    host_e       winner;
    host_e       rsp_host_q;
    dev_e        win_dev;
    dev_e        rsp_dev_q;
    logic        rsp_valid_q;
    logic        grant;
    logic        win_we;
    logic [3:0]  win_be;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        rsp_active;
    logic        dev_ok;
    logic [31:0] rsp_rdata;

    // SRAM takes precedence should the two windows ever be configured to overlap.
    function automatic dev_e decode(input logic [31:0] addr);
        dev_e d;
        d = DEV_ERR;
        if ((addr & ~MemMask) == MemStart) begin
            d = DEV_MEM;
        end else if ((addr & ~DbgMask) == DbgStart) begin
            d = DEV_DBG;
        end
        return d;
    endfunction

    always_comb begin
        winner = HOST_INSTR;
        if (instr_req_i && data_req_i) begin
            if (last_q == HOST_INSTR) begin
                winner = HOST_DATA;
            end
        end else if (data_req_i) begin
            winner = HOST_DATA;
        end
        grant = rst_ni && (instr_req_i || data_req_i);
    end

    // Instruction fetches are always full-word reads.
    always_comb begin
        if (winner == HOST_DATA) begin
            win_we    = data_we_i;
            win_be    = data_be_i;
            win_addr  = data_addr_i;
            win_wdata = data_wdata_i;
        end else begin
            win_we    = 1'b0;
            win_be    = 4'hF;
            win_addr  = instr_addr_i;
            win_wdata = 32'h0;
        end
        win_dev = decode(win_addr);
    end

    always_comb begin
        instr_gnt_o = grant && (winner == HOST_INSTR);
        data_gnt_o  = grant && (winner == HOST_DATA);
        mem_req_o   = grant && (win_dev == DEV_MEM);
        dbg_req_o   = grant && (win_dev == DEV_DBG);

        mem_we_o    = mem_req_o ? win_we    : 1'b0;
        mem_be_o    = mem_req_o ? win_be    : 4'h0;
        mem_addr_o  = mem_req_o ? win_addr  : 32'h0;
        mem_wdata_o = mem_req_o ? win_wdata : 32'h0;
        dbg_we_o    = dbg_req_o ? win_we    : 1'b0;
        dbg_be_o    = dbg_req_o ? win_be    : 4'h0;
        dbg_addr_o  = dbg_req_o ? win_addr  : 32'h0;
        dbg_wdata_o = dbg_req_o ? win_wdata : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            last_q      <= HOST_DATA;
            rsp_host_q  <= HOST_INSTR;
            rsp_dev_q   <= DEV_ERR;
        end else begin
            rsp_valid_q <= grant;
            if (grant) begin
                last_q     <= winner;
                rsp_host_q <= winner;
                rsp_dev_q  <= win_dev;
            end
        end
    end

    // A missing device rvalid is reported as an error rather than stalling the host.
    always_comb begin
        rsp_active = rsp_valid_q && rst_ni;
        dev_ok     = ((rsp_dev_q == DEV_MEM) && mem_rvalid_i) ||
                     ((rsp_dev_q == DEV_DBG) && dbg_rvalid_i);
        if (!dev_ok) begin
            rsp_rdata = ErrRdata;
        end else if (rsp_dev_q == DEV_MEM) begin
            rsp_rdata = mem_rdata_i;
        end else begin
            rsp_rdata = dbg_rdata_i;
        end

        instr_rvalid_o = rsp_active && (rsp_host_q == HOST_INSTR);
        data_rvalid_o  = rsp_active && (rsp_host_q == HOST_DATA);
        instr_rdata_o  = instr_rvalid_o ? rsp_rdata : 32'h0;
        data_rdata_o   = data_rvalid_o  ? rsp_rdata : 32'h0;
        instr_err_o    = instr_rvalid_o && !dev_ok;
        data_err_o     = data_rvalid_o  && !dev_ok;
    end

endmodule

// File: tb/tb_ibex_mem_xbar.sv
// Scoreboard bench for ibex_mem_xbar: grants are checked at issue time and the
// expected responses are queued for a monitor that compares every host rvalid.
module tb_ibex_mem_xbar;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        dbg_req_o;
    logic        dbg_we_o;
    logic [3:0]  dbg_be_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_wdata_o;
    logic        dbg_rvalid_i = 1'b0;
    logic [31:0] dbg_rdata_i = 32'h0;

    logic        mem_drop  = 1'b0;
    logic        mem_stray = 1'b0;
    logic        dbg_stray = 1'b0;
    logic [31:0] mem_val   = 32'h0000_0013;
    logic [31:0] dbg_val   = 32'hCAFE_F00D;

    int errors = 0;
    int checks = 0;
    logic [67:0] exp_q[$];

    localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

    ibex_mem_xbar dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .dbg_req_o      (dbg_req_o),
        .dbg_we_o       (dbg_we_o),
        .dbg_be_o       (dbg_be_o),
        .dbg_addr_o     (dbg_addr_o),
        .dbg_wdata_o    (dbg_wdata_o),
        .dbg_rvalid_i   (dbg_rvalid_i),
        .dbg_rdata_i    (dbg_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Devices answer one cycle after a request; rdata is driven every cycle so a
    // wrongly selected device shows up as a data difference.
    always @(posedge clk_i) begin
        mem_rvalid_i <= (mem_req_o && !mem_drop) || mem_stray;
        mem_rdata_i  <= mem_val;
        dbg_rvalid_i <= dbg_req_o || dbg_stray;
        dbg_rdata_i  <= dbg_val;
    end

    always @(negedge clk_i) begin
        logic [67:0] act;
        logic [67:0] exp;
        if (instr_rvalid_o || data_rvalid_o) begin
            act = {instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o,
                   instr_err_o, data_err_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rvalid: got %h, required no response", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("[TB] FAIL response: got %h, required %h", act, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ireq, input logic [31:0] iaddr,
                                  input logic dreq, input logic dwe, input logic [3:0] dbe,
                                  input logic [31:0] daddr, input logic [31:0] dwdata);
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = daddr;
        data_wdata_i = dwdata;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // dev: 0 = SRAM, 1 = debug memory, 2 = unmapped
    task automatic expect_grant(input string name, input logic win_data, input logic [1:0] dev,
                                input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        logic [68:0] pay;
        logic [1:0]  exp_req;
        @(negedge clk_i);
        pay     = {we, be, addr, wdata};
        exp_req = (dev == 2'd0) ? 2'b10 : (dev == 2'd1) ? 2'b01 : 2'b00;
        check_output({name, "_gnt"}, {94'h0, instr_gnt_o, data_gnt_o},
                     win_data ? 96'h1 : 96'h2);
        check_output({name, "_dev_req"}, {94'h0, mem_req_o, dbg_req_o}, {94'h0, exp_req});
        check_output({name, "_mem_payload"}, {27'h0, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                     (dev == 2'd0) ? {27'h0, pay} : 96'h0);
        check_output({name, "_dbg_payload"}, {27'h0, dbg_we_o, dbg_be_o, dbg_addr_o, dbg_wdata_o},
                     (dev == 2'd1) ? {27'h0, pay} : 96'h0);
        if (win_data) begin
            exp_q.push_back({1'b0, 1'b1, 32'h0, rdata, 1'b0, err});
        end else begin
            exp_q.push_back({1'b1, 1'b0, rdata, 32'h0, err, 1'b0});
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        apply_stimulus(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        step();
        step();
        @(negedge clk_i);
        check_output("reset_gnt", {94'h0, instr_gnt_o, data_gnt_o}, 96'h0);
        check_output("reset_dev_req", {94'h0, mem_req_o, dbg_req_o}, 96'h0);
        check_output("reset_rvalid", {94'h0, instr_rvalid_o, data_rvalid_o}, 96'h0);
        step();
        idle();
        rst_ni = 1'b1;
        step();

        // instruction fetch from SRAM
        apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_grant("instr_read", 1'b0, 2'd0, 1'b0, 4'hF, 32'h80, 32'h0, 32'h13, 1'b0);
        step();
        idle();
        step();

        // fresh reset so the first contention must go to instr, then strict alternation
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        apply_stimulus(1'b1, 32'h80, 1'b1, 1'b1, 4'h6, 32'h100, 32'h1234_5678);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                expect_grant("contend_instr", 1'b0, 2'd0, 1'b0, 4'hF, 32'h80, 32'h0, 32'h13, 1'b0);
            end else begin
                expect_grant("contend_data", 1'b1, 2'd0, 1'b1, 4'h6, 32'h100, 32'h1234_5678,
                             32'h13, 1'b0);
            end
            step();
        end
        idle();
        step();

        // debug memory read, with a stray SRAM rvalid alongside the tagged debug response
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000_0800, 32'h0);
        mem_stray = 1'b1;
        expect_grant("dbg_read", 1'b1, 2'd1, 1'b0, 4'hF, 32'h1000_0800, 32'h0,
                     32'hCAFE_F00D, 1'b0);
        step();
        mem_stray = 1'b0;
        idle();
        step();

        // unmapped address
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
        expect_grant("unmapped", 1'b1, 2'd2, 1'b0, 4'hF, 32'h2000_0000, 32'h0, ERR_RDATA, 1'b1);
        step();
        idle();
        step();

        // SRAM granted but never answers; debug rvalid stray during the same response
        mem_drop  = 1'b1;
        dbg_stray = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h40, 32'h0);
        expect_grant("mem_no_rvalid", 1'b1, 2'd0, 1'b0, 4'h3, 32'h40, 32'h0, ERR_RDATA, 1'b1);
        step();
        mem_drop  = 1'b0;
        dbg_stray = 1'b0;
        idle();
        step();

        // stray SRAM rvalid while idle must not reach either host
        mem_stray = 1'b1;
        step();
        mem_stray = 1'b0;
        @(negedge clk_i);
        check_output("stray_rvalid", {94'h0, instr_rvalid_o, data_rvalid_o}, 96'h0);
        step();

        // reset during the response cycle drops the pending response
        apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check_output("pre_reset_gnt", {94'h0, instr_gnt_o, data_gnt_o}, 96'h2);
        step();
        idle();
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_output("reset_rsp_cycle_rvalid", {94'h0, instr_rvalid_o, data_rvalid_o}, 96'h0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_output("post_reset_rvalid", {94'h0, instr_rvalid_o, data_rvalid_o}, 96'h0);
        step();
        @(negedge clk_i);
        check_output("post_reset_rvalid2", {94'h0, instr_rvalid_o, data_rvalid_o}, 96'h0);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        mem_val = 32'h0BAD_F00D;
        expect_grant("post_reset_read", 1'b1, 2'd0, 1'b0, 4'hF, 32'h200, 32'h0,
                     32'h0BAD_F00D, 1'b0);
        step();
        idle();
        step();
        step();

        @(negedge clk_i);
        check_output("scoreboard_drained", {64'h0, 32'(exp_q.size())}, 96'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
